mem_line_responder: RTL and testbench

- Main-memory responder for the cache controller's memory-side bus: accepts cache-line read (allocate) and write-back requests and returns a one-cycle ready pulse after a programmable latency.
- Sits on the slave end of the memory interface, opposite the cache FSM; used as the bench/system memory behind the 4-way cache.
- Includes a sticky protocol checker for requester misbehaviour.

---
 rtl/mem_line_responder_pkg.sv | 27 ++
 rtl/mem_line_responder_store.sv | 36 +++
 rtl/mem_line_responder.sv | 136 +++++++++++++
 tb/tb_mem_line_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the memory-side responder: line geometry, responder
// states and the latched request record.
package mem_line_responder_pkg;

    localparam int MEM_LINE_W         = 512;
    localparam int MEM_WORDS_PER_LINE = 16;
    localparam int MEM_OFFSET_BITS    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_type;

    typedef struct packed {
        logic                  rw;
        logic [31:0]           addr;
        logic [MEM_LINE_W-1:0] data;
    } mem_req_type;

    // Power-on content of one 32-bit word: line number in the upper bits,
    // word number in the low nibble.
    function automatic logic [31:0] init_word(input int unsigned line, input int unsigned word);
        return 32'((line << 4) | word);
    endfunction

endpackage

// File: rtl/mem_line_responder_store.sv
// Line-wide storage array: combinational read port, synchronous write port,
// preloaded with a recognisable per-line pattern for simulation.
module mem_line_store
    import mem_line_responder_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [LINE_W-1:0] wr_data_i
);

    logic [LINE_W-1:0] mem_q [DEPTH];

    initial begin
        for (int l = 0; l < DEPTH; l++) begin
            for (int w = 0; w < LINE_W / 32; w++) begin
                mem_q[l][w*32 +: 32] = init_word(l, w);
            end
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side slave for the cache: accepts line reads and write-backs and
// answers each with a single ready pulse after a fixed latency.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 8,
    parameter int WR_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic              ready,
    output logic [LINE_W-1:0] rd_data,
    output logic              busy,
    output logic              proto_err
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_resp_state_type state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mem_req_type        req_q, req_d;
    logic [LINE_W-1:0]  rd_data_q, rd_data_d;
    logic               proto_err_q, proto_err_d;

    logic [IDX_W-1:0]   in_idx;
    logic [IDX_W-1:0]   req_idx;
    logic [CNT_W-1:0]   load_val;
    logic [LINE_W-1:0]  store_rdata;
    logic               store_we;
    logic               unused_req_addr;

    assign in_idx          = addr[MEM_OFFSET_BITS +: IDX_W];
    assign req_idx         = req_q.addr[MEM_OFFSET_BITS +: IDX_W];
    assign unused_req_addr = ^req_q.addr;
    assign load_val        = rw ? WR_LOAD : RD_LOAD;
    assign proto_err       = proto_err_q;

    mem_line_store #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk       (clk),
        .rd_idx_i  (req_idx),
        .rd_data_o (store_rdata),
        .we_i      (store_we),
        .wr_idx_i  (req_idx),
        .wr_data_i (LINE_W'(req_q.data))
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rd_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rd_data_q   <= rd_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Handshake: a request is taken on any IDLE cycle with valid high; the
    // requester then holds valid, rw and the line address steady until the
    // ready cycle. In that ready cycle it may already swap rw/addr for its
    // next request (valid stays high), which is accepted one cycle later.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rd_data_d   = rd_data_q;
        proto_err_d = proto_err_q;
        ready       = 1'b0;
        busy        = 1'b0;
        store_we    = 1'b0;
        rd_data     = rd_data_q;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    req_d.rw   = rw;
                    req_d.addr = 32'(addr);
                    req_d.data = MEM_LINE_W'(wr_data);
                    cnt_d      = load_val;
                    state_d    = (load_val == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end
                if (!valid || (rw != req_q.rw) || (in_idx != req_idx)) begin
                    proto_err_d = 1'b1;
                end
            end
            RESP: begin
                busy    = 1'b1;
                ready   = 1'b1;
                state_d = IDLE;
                // rw/addr may already belong to the next request here.
                if (!valid) begin
                    proto_err_d = 1'b1;
                end
                if (req_q.rw) begin
                    store_we = !rst;
                end else begin
                    rd_data   = store_rdata;
                    rd_data_d = store_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed plus randomized bench for mem_line_responder: a default-latency
// instance and a single-cycle-latency instance against a line-level model.
module tb_mem_line_responder;

    logic         clk;
    logic         rst0, rst1;
    logic         sel;
    logic         valid, rw;
    logic [31:0]  addr;
    logic [511:0] wr_data;

    logic         ready0, busy0, perr0;
    logic [511:0] rd_data0;
    logic         ready1, busy1, perr1;
    logic [511:0] rd_data1;

    logic         valid0, valid1;
    logic         ready_s, busy_s, perr_s;
    logic [511:0] rd_data_s;

    int tests;
    int fails;

    logic [511:0] written [int];
    logic [511:0] last_rd [2];

    assign valid0    = valid & ~sel;
    assign valid1    = valid & sel;
    assign ready_s   = sel ? ready1 : ready0;
    assign busy_s    = sel ? busy1 : busy0;
    assign perr_s    = sel ? perr1 : perr0;
    assign rd_data_s = sel ? rd_data1 : rd_data0;

    mem_line_responder dut0 (
        .clk       (clk),
        .rst       (rst0),
        .valid     (valid0),
        .rw        (rw),
        .addr      (addr),
        .wr_data   (wr_data),
        .ready     (ready0),
        .rd_data   (rd_data0),
        .busy      (busy0),
        .proto_err (perr0)
    );

    mem_line_responder #(.RD_LAT(1), .WR_LAT(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .valid     (valid1),
        .rw        (rw),
        .addr      (addr),
        .wr_data   (wr_data),
        .ready     (ready1),
        .rd_data   (rd_data1),
        .busy      (busy1),
        .proto_err (perr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [511:0] pattern(input int l);
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = 32'(l * 16 + w);
        return v;
    endfunction

    function automatic int key_of(input logic s, input logic [31:0] a);
        return (s ? 1024 : 0) + int'((a >> 6) & 32'h3FF);
    endfunction

    function automatic logic [511:0] model_line(input logic s, input logic [31:0] a);
        int k;
        k = key_of(s, a);
        if (written.exists(k)) return written[k];
        return pattern(k % 1024);
    endfunction

    function automatic logic [511:0] fill(input logic [31:0] w);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = w;
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge
    // of the first IDLE cycle after the ready cycle.
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [511:0] d,
                          input string tag, input logic chain, input logic [31:0] next_a,
                          input int glitch);
        int           lat;
        logic [511:0] exp_rd;
        lat     = sel ? 1 : 8;
        valid   = 1'b1;
        rw      = wr;
        addr    = a;
        wr_data = d;
        exp_rd  = wr ? last_rd[sel] : model_line(sel, a);
        for (int k = 1; k <= lat; k++) begin
            if (glitch != 0 && k == glitch) valid = 1'b0;
            if (glitch != 0 && k == glitch + 1) valid = 1'b1;
            @(negedge clk);
            check_bit({tag, "_ready"}, ready_s, k == lat);
            check_bit({tag, "_busy"}, busy_s, 1'b1);
        end
        check_line({tag, "_rd_data"}, rd_data_s, exp_rd);
        if (wr) written[key_of(sel, a)] = d;
        else last_rd[sel] = exp_rd;
        if (chain) begin
            rw   = 1'b0;
            addr = next_a;
            @(negedge clk);
        end else begin
            @(posedge clk);
            #1 valid = 1'b0;
            @(negedge clk);
        end
        check_bit({tag, "_ready_after"}, ready_s, 1'b0);
        check_bit({tag, "_busy_after"}, busy_s, 1'b0);
        check_line({tag, "_rd_hold"}, rd_data_s, last_rd[sel]);
    endtask

    task automatic txn(input logic wr, input logic [31:0] a, input logic [511:0] d, input string tag);
        do_txn(wr, a, d, tag, 1'b0, 32'h0, 0);
    endtask

    task automatic pulse_reset0();
        rst0 = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        last_rd[0] = '0;
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] d;
        logic [31:0]  a;
        logic         wr;
        tests   = 0;
        fails   = 0;
        sel     = 1'b0;
        rst0    = 1'b1;
        rst1    = 1'b1;
        valid   = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        wr_data = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        check_bit("rst_ready0", ready0, 1'b0);
        check_bit("rst_busy0", busy0, 1'b0);
        check_bit("rst_perr0", perr0, 1'b0);
        check_line("rst_rd_data0", rd_data0, '0);
        check_bit("rst_ready1", ready1, 1'b0);
        check_line("rst_rd_data1", rd_data1, '0);

        // Default latency read of line 5, then write/read of the same line.
        txn(1'b0, 32'h0000_0140, '0, "rd_line5");
        check_line("rd_line5_w0", {480'h0, rd_data0[31:0]}, {480'h0, 32'h50});
        check_line("rd_line5_w15", {480'h0, rd_data0[511:480]}, {480'h0, 32'h5F});
        txn(1'b1, 32'h0000_0140, fill(32'hDEAD_BEEF), "wr_line5");
        txn(1'b0, 32'h0000_0140, '0, "raw_line5");
        check_bit("perr_after_raw", perr0, 1'b0);

        // Write-back of aliased line 1 chained straight into an allocate of line 2.
        do_txn(1'b1, 32'h0001_0040, fill(32'h1234_5678), "wb_chain", 1'b1, 32'h0002_0080, 0);
        txn(1'b0, 32'h0002_0080, '0, "alloc_chain");
        txn(1'b0, 32'h0000_0040, '0, "rd_line1_updated");
        check_bit("perr_after_chain", perr0, 1'b0);

        // valid dropped for one WAIT cycle: sticky error, transaction unaffected.
        do_txn(1'b0, 32'h0000_0100, '0, "glitch_rd", 1'b0, 32'h0, 3);
        check_bit("perr_set", perr0, 1'b1);
        txn(1'b0, 32'h0000_0180, '0, "post_glitch_rd");
        check_bit("perr_sticky", perr0, 1'b1);
        pulse_reset0();
        check_bit("perr_cleared", perr0, 1'b0);
        check_line("rd_data_cleared", rd_data0, '0);

        // Reset four cycles into a write of line 3: no response, no commit.
        valid   = 1'b1;
        rw      = 1'b1;
        addr    = 32'h0000_00C0;
        wr_data = fill(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        rst0  = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        rst0 = 1'b0;
        last_rd[0] = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_bit("midrst_no_ready", ready0, 1'b0);
        end
        check_bit("midrst_busy", busy0, 1'b0);
        txn(1'b0, 32'h0000_00C0, '0, "rd_line3_after_rst");

        // Randomized traffic over a few lines with aliasing upper address bits.
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 6) | 32'($urandom_range(0, 63));
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            txn(wr, a, d, wr ? "rand_wr" : "rand_rd");
        end
        check_bit("perr_after_rand", perr0, 1'b0);

        // Single-cycle latency instance, including index wrap.
        sel = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h0000_0140, '0, "lat1_rd_line5");
        txn(1'b0, 32'h0001_0000, '0, "lat1_wrap_line0");
        txn(1'b1, 32'h0000_0200, fill(32'hA5A5_5A5A), "lat1_wr_line8");
        txn(1'b0, 32'h0000_0200, '0, "lat1_raw_line8");
        for (int n = 0; n < 12; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 6);
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            txn(wr, a, d, wr ? "lat1_rand_wr" : "lat1_rand_rd");
        end
        check_bit("lat1_perr", perr1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
